// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   - Default reset PC and NOP word used by fetch_stage and if_id_register.
//   - Bytes per instruction word.
//   - FSM state encoding for the fetch sequencer.
//   - Helper that classifies a redirect target as unusable.
package fetch_stage_pkg;

    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;
    localparam int unsigned WORD_BYTES    = 4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    // A redirect target is unusable if it is not word aligned or lies at or
    // beyond the end of instruction memory.
    function automatic logic target_is_bad(input logic [31:0] target,
                                           input logic [31:0] byte_limit);
        return (target[1:0] != 2'b00) || (target >= byte_limit);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and a combinational memory.
//   imem_pc           byte address presented by the fetch stage
//   imem_instruction  word returned by the memory in the same cycle
// Modports: master = fetch stage, slave = instruction memory.
interface fetch_stage_if;

    logic [31:0] imem_pc;
    logic [31:0] imem_instruction;

    modport master (
        output imem_pc,
        input  imem_instruction
    );

    modport slave (
        input  imem_pc,
        output imem_instruction
    );

endinterface

// File: rtl/fetch_stage_if_id_register.sv
// IF/ID pipeline register.
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset (empties the register)
//   load_i         capture {valid, pc, pc+4, instruction}
//   flush_i        replace contents with a bubble (takes precedence over load)
//   pc_i           byte address of the word being captured
//   pc_plus4_i     pc_i + 4
//   instruction_i  word being captured
//   valid_o / pc_o / pc_plus4_o / instruction_o   registered contents
// With neither load nor flush the contents hold (stall).
module if_id_register
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        flush_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] pc_plus4_i,
    input  logic [31:0] instruction_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] instruction_o
);

    logic        valid_q;
    logic [31:0] pc_q;
    logic [31:0] pc_plus4_q;
    logic [31:0] instruction_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q       <= 1'b0;
            pc_q          <= 32'h0;
            pc_plus4_q    <= 32'h0;
            instruction_q <= NOP_INSTR;
        end else if (flush_i) begin
            valid_q       <= 1'b0;
            pc_q          <= 32'h0;
            pc_plus4_q    <= 32'h0;
            instruction_q <= NOP_INSTR;
        end else if (load_i) begin
            valid_q       <= 1'b1;
            pc_q          <= pc_i;
            pc_plus4_q    <= pc_plus4_i;
            instruction_q <= instruction_i;
        end
    end

    assign valid_o       = valid_q;
    assign pc_o          = pc_q;
    assign pc_plus4_o    = pc_plus4_q;
    assign instruction_o = instruction_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the 32-bit MIPS-style core.
// Owns the program counter, presents it to the combinational instruction
// memory and captures the returned word into the IF/ID register.
//   clk                 rising-edge clock
//   rst_n               asynchronous active-low reset
//   imem                instruction-memory bus (master side)
//   stall_i             hold PC and IF/ID this cycle
//   redirect_i          taken branch/jump: load redirect_pc_i and flush IF/ID
//   redirect_pc_i       redirect target byte address
//   if_id_valid_o       IF/ID holds a real instruction
//   if_id_pc_o          byte address of if_id_instruction_o
//   if_id_pc_plus4_o    if_id_pc_o + 4
//   if_id_instruction_o fetched word, NOP_INSTR when not valid
//   halted_o            fetch ran off the end of memory
//   fault_o             a redirect targeted a bad address (sticky until reset)
// Edge priority: redirect > stall > advance.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter int unsigned IMEM_WORDS = 128,
    parameter logic [31:0] NOP_INSTR  = DEF_NOP_INSTR
) (
    input  logic                clk,
    input  logic                rst_n,
    fetch_stage_if.master       imem,
    input  logic                stall_i,
    input  logic                redirect_i,
    input  logic [31:0]         redirect_pc_i,
    output logic                if_id_valid_o,
    output logic [31:0]         if_id_pc_o,
    output logic [31:0]         if_id_pc_plus4_o,
    output logic [31:0]         if_id_instruction_o,
    output logic                halted_o,
    output logic                fault_o
);

    localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * WORD_BYTES);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         halted_q;
    logic         fault_q;

    logic [31:0]  pc_plus4;
    logic         redirect_bad;
    logic         ifid_load;
    logic         ifid_flush;

    assign pc_plus4     = pc_q + 32'd4;
    assign redirect_bad = target_is_bad(redirect_pc_i, PC_LIMIT);
    assign imem.imem_pc = pc_q;

    // Next-state / next-PC selection and IF/ID control.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;

        unique case (state_q)
            ST_RUN, ST_HALT: begin
                if (redirect_i) begin
                    // The redirected PC is loaded even when the target is bad;
                    // FAULT clears it on the following edge.
                    ifid_flush = 1'b1;
                    pc_d       = redirect_pc_i;
                    state_d    = redirect_bad ? ST_FAULT : ST_RUN;
                end else if (stall_i) begin
                    // Hold everything.
                end else if (state_q == ST_RUN) begin
                    ifid_load = 1'b1;
                    pc_d      = pc_plus4;
                    // The last word is still delivered; only the next fetch stops.
                    if (pc_plus4 == PC_LIMIT) begin
                        state_d = ST_HALT;
                    end
                end else begin
                    // HALT: PC parked at the limit, drain IF/ID to a bubble.
                    ifid_flush = 1'b1;
                end
            end
            ST_FAULT: begin
                ifid_flush = 1'b1;
                pc_d       = 32'h0;
            end
            default: begin
                ifid_flush = 1'b1;
                pc_d       = 32'h0;
                state_d    = ST_FAULT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            halted_q <= (state_d == ST_HALT);
            fault_q  <= (state_d == ST_FAULT);
        end
    end

    if_id_register #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (ifid_load),
        .flush_i      (ifid_flush),
        .pc_i         (pc_q),
        .pc_plus4_i   (pc_plus4),
        .instruction_i(imem.imem_instruction),
        .valid_o      (if_id_valid_o),
        .pc_o         (if_id_pc_o),
        .pc_plus4_o   (if_id_pc_plus4_o),
        .instruction_o(if_id_instruction_o)
    );

    assign halted_o = halted_q;
    assign fault_o  = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised and directed bench for fetch_stage against a behavioural model.
module tb_fetch_stage;

    localparam logic [31:0] NOP   = 32'h0000_0000;
    localparam int unsigned WORDS = 128;
    localparam logic [31:0] LIMIT = 32'(WORDS * 4);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instruction;
    logic        halted;
    logic        fault;

    logic [31:0] mem [0:WORDS-1];

    int checks = 0;
    int errors = 0;

    // Behavioural model of the visible state.
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_ipc;
    logic [31:0] m_ip4;
    logic [31:0] m_instr;
    logic        m_halt;
    logic        m_fault;

    fetch_stage_if bus();

    assign bus.imem_instruction = (bus.imem_pc < LIMIT) ? mem[bus.imem_pc[8:2]] : 32'hDEAD_BEEF;

    fetch_stage #(
        .RESET_PC  (32'h0),
        .IMEM_WORDS(WORDS),
        .NOP_INSTR (NOP)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .imem               (bus.master),
        .stall_i            (stall),
        .redirect_i         (redirect),
        .redirect_pc_i      (redirect_pc),
        .if_id_valid_o      (if_id_valid),
        .if_id_pc_o         (if_id_pc),
        .if_id_pc_plus4_o   (if_id_pc_plus4),
        .if_id_instruction_o(if_id_instruction),
        .halted_o           (halted),
        .fault_o            (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_valid = 1'b0;
        m_ipc   = 32'h0;
        m_ip4   = 32'h0;
        m_instr = NOP;
        m_halt  = 1'b0;
        m_fault = 1'b0;
    endtask

    task automatic model_edge(input logic s, input logic r, input logic [31:0] rpc);
        if (m_fault) begin
            m_valid = 1'b0;
            m_instr = NOP;
        end else if (r) begin
            m_valid = 1'b0;
            m_instr = NOP;
            m_pc    = rpc;
            if ((rpc % 4) != 0 || rpc >= LIMIT) m_fault = 1'b1;
            else m_halt = 1'b0;
        end else if (s) begin
            // nothing changes
        end else if (m_halt) begin
            m_valid = 1'b0;
            m_instr = NOP;
        end else begin
            m_valid = 1'b1;
            m_ipc   = m_pc;
            m_ip4   = m_pc + 4;
            m_instr = mem[m_pc / 4];
            m_pc    = m_pc + 4;
            if (m_pc == LIMIT) m_halt = 1'b1;
        end
    endtask

    task automatic compare_all();
        chk("valid", {31'b0, if_id_valid}, {31'b0, m_valid});
        chk("instr", if_id_instruction, m_instr);
        chk("halted", {31'b0, halted}, {31'b0, m_halt && !m_fault});
        chk("fault", {31'b0, fault}, {31'b0, m_fault});
        if (m_valid) begin
            chk("if_id_pc", if_id_pc, m_ipc);
            chk("if_id_pc4", if_id_pc_plus4, m_ip4);
        end
        if (!m_fault) chk("imem_pc", bus.imem_pc, m_pc);
    endtask

    task automatic step(input logic s, input logic r, input logic [31:0] rpc);
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        @(posedge clk);
        model_edge(s, r, rpc);
        #1;
        compare_all();
    endtask

    // Asserts reset between edges and checks outputs before any clock edge.
    task automatic do_reset();
        stall    = 1'b0;
        redirect = 1'b0;
        rst_n    = 1'b0;
        #1;
        model_reset();
        chk("rst_valid", {31'b0, if_id_valid}, 32'h0);
        chk("rst_instr", if_id_instruction, NOP);
        chk("rst_pc", if_id_pc, 32'h0);
        chk("rst_pc4", if_id_pc_plus4, 32'h0);
        chk("rst_halted", {31'b0, halted}, 32'h0);
        chk("rst_fault", {31'b0, fault}, 32'h0);
        chk("rst_imem_pc", bus.imem_pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int r;
        logic [31:0] tgt;
        for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
        mem[0]  = 32'hB408_0064;
        mem[1]  = 32'hB709_0064;
        mem[10] = 32'h0109_5025;

        #3;
        do_reset();

        // Free-running fetch from reset.
        step(0, 0, 0);
        chk("t1_pc0", if_id_pc, 32'h0);
        chk("t1_w0", if_id_instruction, 32'hB408_0064);
        step(0, 0, 0);
        chk("t1_pc4", if_id_pc, 32'h4);
        chk("t1_w1", if_id_instruction, 32'hB709_0064);

        // Stall for two cycles at pc=8.
        step(1, 0, 0);
        step(1, 0, 0);
        chk("t2_imem_pc", bus.imem_pc, 32'h8);
        chk("t2_hold_pc", if_id_pc, 32'h4);
        chk("t2_hold_w", if_id_instruction, 32'hB709_0064);
        step(0, 0, 0);
        chk("t2_resume", if_id_pc, 32'h8);

        // Redirect together with stall.
        step(1, 1, 32'h28);
        chk("t3_flush_v", {31'b0, if_id_valid}, 32'h0);
        chk("t3_flush_nop", if_id_instruction, NOP);
        step(0, 0, 0);
        chk("t3_pc", if_id_pc, 32'h28);
        chk("t3_w", if_id_instruction, 32'h0109_5025);

        // Run to the end of memory.
        step(0, 1, 32'h1F0);
        for (int i = 0; i < 10 && !m_halt; i++) step(0, 0, 0);
        chk("t4_halted", {31'b0, halted}, 32'h1);
        chk("t4_last_v", {31'b0, if_id_valid}, 32'h1);
        chk("t4_last_pc", if_id_pc, 32'h1FC);
        step(1, 0, 0);
        step(0, 0, 0);
        chk("t4_empty", {31'b0, if_id_valid}, 32'h0);
        step(0, 1, 32'h0);
        chk("t4_run", {31'b0, halted}, 32'h0);
        step(0, 0, 0);
        chk("t4_pc0", if_id_pc, 32'h0);

        // Bad redirect targets.
        step(0, 1, 32'h2A);
        chk("t5_fault_a", {31'b0, fault}, 32'h1);
        step(0, 1, 32'h10);
        step(1, 1, 32'h10);
        chk("t5_sticky", {31'b0, fault}, 32'h1);
        do_reset();
        step(0, 0, 0);
        step(0, 1, 32'h200);
        chk("t5_fault_r", {31'b0, fault}, 32'h1);
        step(0, 0, 0);
        do_reset();

        // Reset mid-fetch.
        for (int i = 0; i < 5; i++) step(0, 0, 0);
        do_reset();

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (m_fault && r < 40) begin
                do_reset();
            end else if (r < 10) begin
                case ($urandom_range(0, 9))
                    0:       tgt = {$urandom_range(0, 127), 2'b00} | 32'h1 << $urandom_range(0, 1);
                    1:       tgt = LIMIT + 32'({$urandom_range(0, 255), 2'b00});
                    2, 3, 4: tgt = 32'({$urandom_range(112, 127), 2'b00});
                    default: tgt = 32'({$urandom_range(0, 127), 2'b00});
                endcase
                step($urandom_range(0, 1) == 1, 1'b1, tgt);
            end else begin
                step(r < 35, 1'b0, 32'({$urandom_range(0, 255), 2'b00}));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
